// File: rtl/sys_input_handler.sv
// sys_input_handler: services read_int ($v0=5) and read_char ($v0=12) syscalls.
// On a qualifying syscall in execute it stalls the pipeline, pulls one word from
// an input stream over valid/ready, writes it to $v0 and releases the stall.
// A wait longer than TIMEOUT cycles writes all ones and sets a sticky error.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   issue_i         instruction present in execute this cycle
//   opcode_i        opcode of that instruction (syscall = 6'b011001)
//   regv_i          current $v0 (syscall code)
//   stall_o         pipeline hold while a read is outstanding
//   in_valid_i      input stream has a word
//   in_data_i       input stream word
//   in_ready_o      word accepted this cycle
//   wr_en_o         register-file write strobe
//   wr_addr_o       register-file write address (2 when writing, else 0)
//   wr_data_o       register-file write data
//   err_o           sticky timeout flag
//   req_count_o     completed reads, timed-out ones included (wraps)
module sys_input_handler #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_i,
  input  logic [5:0]        opcode_i,
  input  logic [DATA_W-1:0] regv_i,
  output logic              stall_o,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              wr_en_o,
  output logic [4:0]        wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  req_count_o
);

  localparam logic [5:0]   OpSyscall = 6'b011001;
  localparam int unsigned  TmoW      = $clog2(TIMEOUT) + 1;
  // Last WAIT cycle index before giving up; unused when TIMEOUT is 0.
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);
  localparam logic [TmoW-1:0] TmoMax  = '1;

  typedef enum logic [1:0] {StIdle, StWait, StWrite} state_e;

  state_e            state_q, state_d;
  logic              is_char_q, is_char_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic code_int, code_char, start;

  assign code_int  = (regv_i == DATA_W'(5));
  assign code_char = (regv_i == DATA_W'(12));
  assign start     = (state_q == StIdle) && issue_i && (opcode_i == OpSyscall) &&
                     (code_int || code_char);

  always_comb begin
    state_d    = state_q;
    is_char_d  = is_char_q;
    tmo_d      = tmo_q;
    data_d     = data_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    stall_o    = start;
    in_ready_o = 1'b0;
    wr_en_o    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          is_char_d = code_char;
          tmo_d     = '0;
          state_d   = StWait;
        end
      end
      StWait: begin
        stall_o    = 1'b1;
        in_ready_o = 1'b1;
        // A word arriving on the last allowed cycle still wins over the timeout.
        if (in_valid_i) begin
          data_d  = is_char_q ? {{(DATA_W-8){1'b0}}, in_data_i[7:0]} : in_data_i;
          state_d = StWrite;
        end else if ((TIMEOUT != 0) && (tmo_q == TmoLast)) begin
          data_d  = '1;
          err_d   = 1'b1;
          state_d = StWrite;
        end else if (tmo_q != TmoMax) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StWrite: begin
        wr_en_o = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Reset suppresses the write and leaves any offered word unconsumed.
    if (rst) begin
      in_ready_o = 1'b0;
      wr_en_o    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      is_char_q <= 1'b0;
      tmo_q     <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      is_char_q <= is_char_d;
      tmo_q     <= tmo_d;
      data_q    <= data_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign wr_addr_o   = wr_en_o ? 5'd2 : 5'd0;
  assign wr_data_o   = data_q;
  assign err_o       = err_q;
  assign req_count_o = cnt_q;

endmodule

// File: tb/tb_sys_input_handler.sv
module tb_sys_input_handler;

  localparam int unsigned TO = 16;
  localparam int unsigned CW = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue = 1'b0;
  logic [5:0]  opcode = '0;
  logic [31:0] regv = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        stall, in_ready, wr_en, err;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [CW-1:0] req_count;

  sys_input_handler #(.DATA_W(32), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_i     (issue),
    .opcode_i    (opcode),
    .regv_i      (regv),
    .stall_o     (stall),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .wr_en_o     (wr_en),
    .wr_addr_o   (wr_addr),
    .wr_data_o   (wr_data),
    .err_o       (err),
    .req_count_o (req_count)
  );

  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;
  int req_model = 0;
  bit err_model = 1'b0;

  typedef struct {
    logic [5:0]  opc;
    logic [31:0] regv;
    int          delay;     // WAIT cycle (0-based) on which in_valid rises
    logic [31:0] data;
    int          gap;       // idle cycles before the issue
    int          exp_stall; // 0 means the issue must be ignored
    logic [31:0] exp_data;
    bit          exp_to;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference rules: a read lasts (accept cycle or timeout cycle) WAIT cycles plus the issue.
  function automatic int model_stall(input logic [5:0] opc, input logic [31:0] rv,
                                     input int delay);
    if (!(opc == 6'b011001 && (rv == 32'd5 || rv == 32'd12))) return 0;
    return ((delay < int'(TO)) ? delay + 1 : int'(TO)) + 1;
  endfunction

  function automatic logic [31:0] model_data(input logic [31:0] rv, input int delay,
                                             input logic [31:0] d);
    if (delay >= int'(TO)) return 32'hFFFF_FFFF;
    if (rv == 32'd12) return {24'h0, d[7:0]};
    return d;
  endfunction

  task automatic run_txn(input logic [5:0] a_opc, input logic [31:0] a_regv, input int delay,
                         input logic [31:0] a_data, input int gap, input int exp_stall,
                         input logic [31:0] exp_data, input bit exp_to, input bit noise);
    int stalls;
    int readies;
    bit done;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      issue = 1'b0; in_valid = 1'($urandom % 2); in_data = $urandom; #1;
      check("idle_stall", 32'(stall), 32'd0);
      check("idle_in_ready", 32'(in_ready), 32'd0);
      check("idle_wr_en", 32'(wr_en), 32'd0);
    end
    @(negedge clk);
    issue = 1'b1; opcode = a_opc; regv = a_regv; in_valid = 1'b0; #1;
    check("req_count", 32'(req_count), 32'(req_model));
    check("err", 32'(err), 32'(err_model));
    check("issue_stall", 32'(stall), 32'(exp_stall != 0));
    check("issue_in_ready", 32'(in_ready), 32'd0);
    check("issue_wr_en", 32'(wr_en), 32'd0);
    if (exp_stall == 0) return;
    stalls = 1; readies = 0; done = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      // Issues outside IDLE must be ignored.
      issue = noise ? 1'($urandom % 2) : 1'b0;
      opcode = 6'b011001; regv = 32'd5;
      in_valid = (k == delay);
      in_data = (k == delay) ? a_data : $urandom;
      #1;
      if (!stall) begin
        done = 1'b1;
        break;
      end
      stalls++;
      if (in_ready) readies++;
      if (wr_en) check("wait_wr_en", 32'(wr_en), 32'd0);
    end
    if (!done) begin
      nchk++; nerr++;
      $display("FAIL stall_bound: got stall stuck expected release");
      return;
    end
    check("stall_len", 32'(stalls), 32'(exp_stall));
    check("in_ready_len", 32'(readies), 32'(exp_stall - 1));
    check("write_wr_en", 32'(wr_en), 32'd1);
    check("write_wr_addr", 32'(wr_addr), 32'd2);
    check("write_wr_data", wr_data, exp_data);
    check("write_in_ready", 32'(in_ready), 32'd0);
    req_model = (req_model + 1) % (1 << CW);
    err_model = err_model | exp_to;
  endtask

  initial begin
    vecs[0]  = '{6'b011001, 32'd5,  0,  32'hDEAD_BEEF, 1, 2,  32'hDEAD_BEEF, 1'b0};
    vecs[1]  = '{6'b011001, 32'd12, 6,  32'h1234_5641, 0, 8,  32'h0000_0041, 1'b0};
    vecs[2]  = '{6'b011001, 32'd1,  0,  32'h0,         2, 0,  32'h0,         1'b0};
    vecs[3]  = '{6'b011001, 32'd10, 0,  32'h0,         2, 0,  32'h0,         1'b0};
    vecs[4]  = '{6'b011001, 32'd11, 0,  32'h0,         1, 0,  32'h0,         1'b0};
    vecs[5]  = '{6'b000000, 32'd5,  0,  32'h0,         1, 0,  32'h0,         1'b0};
    vecs[6]  = '{6'b011001, 32'd5,  99, 32'h0,         1, 17, 32'hFFFF_FFFF, 1'b1};
    vecs[7]  = '{6'b011001, 32'd5,  2,  32'hCAFE_0001, 0, 4,  32'hCAFE_0001, 1'b0};
    vecs[8]  = '{6'b011001, 32'd5,  0,  32'h0000_0001, 0, 2,  32'h0000_0001, 1'b0};
    vecs[9]  = '{6'b011001, 32'd5,  0,  32'h0000_0002, 0, 2,  32'h0000_0002, 1'b0};
    vecs[10] = '{6'b011001, 32'd12, 15, 32'hFFFF_FFAB, 0, 17, 32'h0000_00AB, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_req_count", 32'(req_count), 32'd0);

    foreach (vecs[i])
      run_txn(vecs[i].opc, vecs[i].regv, vecs[i].delay, vecs[i].data, vecs[i].gap,
              vecs[i].exp_stall, vecs[i].exp_data, vecs[i].exp_to, 1'b0);

    // Reset during the WRITE cycle: no write, counter cleared.
    @(negedge clk);
    issue = 1'b1; opcode = 6'b011001; regv = 32'd5; in_valid = 1'b0; #1;
    check("err_sticky", 32'(err), 32'd1);
    @(negedge clk);
    issue = 1'b0; in_valid = 1'b1; in_data = 32'h7777_7777;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1; #1;
    check("rst_write_wr_en", 32'(wr_en), 32'd0);
    @(negedge clk);
    rst = 1'b0; #1;
    check("rst_write_req_count", 32'(req_count), 32'd0);
    check("rst_write_err", 32'(err), 32'd0);
    req_model = 0; err_model = 1'b0;

    // Reset in the 3rd WAIT cycle, then a late in_valid that must be ignored.
    @(negedge clk);
    issue = 1'b1; opcode = 6'b011001; regv = 32'd5; in_valid = 1'b0;
    @(negedge clk); issue = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b1; in_data = 32'h5555_5555;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("post_rst_stall", 32'(stall), 32'd0);
      check("post_rst_in_ready", 32'(in_ready), 32'd0);
      check("post_rst_wr_en", 32'(wr_en), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    run_txn(6'b011001, 32'd5, 1, 32'h0BAD_F00D, 0, 3, 32'h0BAD_F00D, 1'b0, 1'b0);

    // Randomized reads checked against the reference rules.
    for (int n = 0; n < 60; n++) begin
      logic [5:0]  opc;
      logic [31:0] rv;
      logic [31:0] d;
      int          dly;
      int          sel;
      opc = ($urandom % 5 != 0) ? 6'b011001 : 6'($urandom);
      sel = int'($urandom % 6);
      case (sel)
        0: rv = 32'd1;
        1: rv = 32'd5;
        2: rv = 32'd10;
        3: rv = 32'd11;
        4: rv = 32'd12;
        default: rv = $urandom;
      endcase
      d   = $urandom;
      dly = int'($urandom_range(0, 20));
      run_txn(opc, rv, dly, d, int'($urandom_range(0, 2)), model_stall(opc, rv, dly),
              model_data(rv, dly, d), dly >= int'(TO), 1'b1);
    end

    @(negedge clk);
    issue = 1'b0; in_valid = 1'b0; #1;
    check("final_req_count", 32'(req_count), 32'(req_model));
    check("final_err", 32'(err), 32'(err_model));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
